// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus chip-select sequencer: FSM states and timing bundle.
package hyperbus_pkg;

   localparam int unsigned CS_TIMER_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACTIVE,
      HOLD,
      RECOVER
   } cs_seq_state_e;

   typedef struct packed {
      logic [CS_TIMER_W-1:0] t_css;
      logic [CS_TIMER_W-1:0] t_csh;
      logic [CS_TIMER_W-1:0] t_cshi;
   } cs_timing_t;

endpackage

// File: rtl/hyperbus_cs_sequencer_lzc.sv
// Lowest-set-bit finder: returns index and one-hot mask of the winning request.
module hyperbus_lzc_onehot #(
   parameter int unsigned Width = 2,
   parameter int unsigned IdxW  = 1
) (
   input  logic [Width-1:0] req_i,
   output logic [IdxW-1:0]  idx_o,
   output logic [Width-1:0] onehot_o,
   output logic             valid_o
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx_o    = '0;
      onehot_o = '0;
      for (int i = int'(Width) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o       = IdxW'(i);
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/hyperbus_cs_sequencer.sv
// Timed CS / clock-enable sequencer in the tx_clk_90 domain (setup, hold, recovery, watchdog).
// Define HYPERBUS_CS_STATS_EN to add transaction and watchdog-expiry counters.
module hyperbus_cs_sequencer
   import hyperbus_pkg::*;
#(
   parameter int unsigned NumChips   = 2,
   parameter int unsigned TimerWidth = CS_TIMER_W,
   parameter int unsigned CsmWidth   = 10,
   localparam int unsigned ChipW     = (NumChips > 1) ? $clog2(NumChips) : 1
) (
   input  logic                  tx_clk_90,
   input  logic                  rst_ni,
   input  logic [NumChips-1:0]   cs_i,
   input  logic                  cs_ena_i,
   input  logic [TimerWidth-1:0] cfg_t_css_i,
   input  logic [TimerWidth-1:0] cfg_t_csh_i,
   input  logic [TimerWidth-1:0] cfg_t_cshi_i,
   input  logic [CsmWidth-1:0]   cfg_t_csm_i,
   output logic [NumChips-1:0]   hyper_cs_no,
   output logic                  ck_ena_o,
   output logic                  busy_o,
   output logic [ChipW-1:0]      active_chip_o,
   output logic                  csm_expired_o
`ifdef HYPERBUS_CS_STATS_EN
   ,
   output logic [31:0]           stat_trx_cnt_o,
   output logic [15:0]           stat_csm_cnt_o
`endif
);

   cs_seq_state_e         r_state, w_state;
   logic [TimerWidth-1:0] r_cnt, w_cnt;
   logic [CsmWidth-1:0]   r_csm, w_csm;
   logic [CsmWidth-1:0]   r_csm_lim, w_csm_lim;
   logic [NumChips-1:0]   r_cs_n, w_cs_n;
   logic                  r_ck_ena, w_ck_ena;
   logic                  r_busy, w_busy;
   logic [ChipW-1:0]      r_chip, w_chip;
   logic                  r_csm_exp, w_csm_exp;

   cs_timing_t            w_tim;
   logic [ChipW-1:0]      w_sel_idx;
   logic [NumChips-1:0]   w_sel_oh;
   logic                  w_sel_vld;

   assign w_tim.t_css  = CS_TIMER_W'(cfg_t_css_i);
   assign w_tim.t_csh  = CS_TIMER_W'(cfg_t_csh_i);
   assign w_tim.t_cshi = CS_TIMER_W'(cfg_t_cshi_i);

   hyperbus_lzc_onehot #(
      .Width (NumChips),
      .IdxW  (ChipW)
   ) u_lzc (
      .req_i    (cs_i),
      .idx_o    (w_sel_idx),
      .onehot_o (w_sel_oh),
      .valid_o  (w_sel_vld)
   );

   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_csm     = r_csm;
      w_csm_lim = r_csm_lim;
      w_cs_n    = r_cs_n;
      w_ck_ena  = r_ck_ena;
      w_chip    = r_chip;
      w_csm_exp = 1'b0;
      case (r_state)
         IDLE: begin
            if (cs_ena_i && w_sel_vld) begin
               w_chip  = w_sel_idx;
               w_cs_n  = ~w_sel_oh;
               w_cnt   = TimerWidth'(w_tim.t_css);
               w_state = SETUP;
            end
         end
         SETUP: begin
            if (!cs_ena_i) begin
               w_cnt   = TimerWidth'(w_tim.t_csh);
               w_state = HOLD;
            end else if (r_cnt == '0) begin
               w_ck_ena  = 1'b1;
               w_csm     = '0;
               w_csm_lim = cfg_t_csm_i;
               w_state   = ACTIVE;
            end else begin
               w_cnt = r_cnt - TimerWidth'(1);
            end
         end
         ACTIVE: begin
            if (r_csm != '1) w_csm = r_csm + CsmWidth'(1);
            if (!cs_ena_i) begin
               w_ck_ena = 1'b0;
               w_cnt    = TimerWidth'(w_tim.t_csh);
               w_state  = HOLD;
            end else if (r_csm_lim != '0 && r_csm == r_csm_lim - CsmWidth'(1)) begin
               // Forced end; RECOVER still waits for cs_ena_i to drop.
               w_csm_exp = 1'b1;
               w_ck_ena  = 1'b0;
               w_cnt     = TimerWidth'(w_tim.t_csh);
               w_state   = HOLD;
            end
         end
         HOLD: begin
            if (r_cnt == '0) begin
               w_cs_n  = '1;
               w_cnt   = TimerWidth'(w_tim.t_cshi);
               w_state = RECOVER;
            end else begin
               w_cnt = r_cnt - TimerWidth'(1);
            end
         end
         RECOVER: begin
            if (r_cnt == '0) begin
               if (!cs_ena_i) w_state = IDLE;
            end else begin
               w_cnt = r_cnt - TimerWidth'(1);
            end
         end
         default: begin
            w_state  = IDLE;
            w_cs_n   = '1;
            w_ck_ena = 1'b0;
         end
      endcase
      w_busy = (w_state != IDLE);
   end

   always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_csm     <= '0;
         r_csm_lim <= '0;
         r_cs_n    <= '1;
         r_ck_ena  <= 1'b0;
         r_busy    <= 1'b0;
         r_chip    <= '0;
         r_csm_exp <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_csm     <= w_csm;
         r_csm_lim <= w_csm_lim;
         r_cs_n    <= w_cs_n;
         r_ck_ena  <= w_ck_ena;
         r_busy    <= w_busy;
         r_chip    <= w_chip;
         r_csm_exp <= w_csm_exp;
      end
   end

   assign hyper_cs_no   = r_cs_n;
   assign ck_ena_o      = r_ck_ena;
   assign busy_o        = r_busy;
   assign active_chip_o = r_chip;
   assign csm_expired_o = r_csm_exp;

`ifdef HYPERBUS_CS_STATS_EN
   logic [31:0] r_trx_cnt;
   logic [15:0] r_csmx_cnt;

   always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
      if (!rst_ni) begin
         r_trx_cnt  <= '0;
         r_csmx_cnt <= '0;
      end else begin
         if (r_state == HOLD && r_cnt == '0) r_trx_cnt <= r_trx_cnt + 32'd1;
         if (w_csm_exp) r_csmx_cnt <= r_csmx_cnt + 16'd1;
      end
   end

   assign stat_trx_cnt_o = r_trx_cnt;
   assign stat_csm_cnt_o = r_csmx_cnt;
`endif

endmodule

// File: tb/tb_hyperbus_cs_sequencer.sv
// Scoreboard bench for hyperbus_cs_sequencer: directed transactions push timed output events,
// a negedge monitor pops and compares them whenever the output vector changes.
module tb_hyperbus_cs_sequencer;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic [1:0] cs_i = 2'b00;
   logic       cs_ena_i = 1'b0;
   logic [3:0] cfg_t_css_i = '0, cfg_t_csh_i = '0, cfg_t_cshi_i = '0;
   logic [9:0] cfg_t_csm_i = '0;
   logic [1:0] hyper_cs_no;
   logic       ck_ena_o, busy_o, csm_expired_o;
   logic [0:0] active_chip_o;
`ifdef HYPERBUS_CS_STATS_EN
   logic [31:0] stat_trx_cnt_o;
   logic [15:0] stat_csm_cnt_o;
`endif

   hyperbus_cs_sequencer #(.NumChips(2), .TimerWidth(4), .CsmWidth(10)) dut (
      .tx_clk_90     (clk),
      .rst_ni        (rst_ni),
      .cs_i          (cs_i),
      .cs_ena_i      (cs_ena_i),
      .cfg_t_css_i   (cfg_t_css_i),
      .cfg_t_csh_i   (cfg_t_csh_i),
      .cfg_t_cshi_i  (cfg_t_cshi_i),
      .cfg_t_csm_i   (cfg_t_csm_i),
      .hyper_cs_no   (hyper_cs_no),
      .ck_ena_o      (ck_ena_o),
      .busy_o        (busy_o),
      .active_chip_o (active_chip_o),
      .csm_expired_o (csm_expired_o)
`ifdef HYPERBUS_CS_STATS_EN
      ,
      .stat_trx_cnt_o(stat_trx_cnt_o),
      .stat_csm_cnt_o(stat_csm_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [5:0] v;
   } ev_t;

   ev_t  q[$];
   ev_t  ev;
   int   checks = 0, errors = 0;
   int   k;
   logic [5:0] prev;
   int   last_rise, rise_cshi;
   bit   seen_rise;

   // Observed vector: {cs_n[1:0], ck_ena, busy, chip, csm_expired}
   wire [5:0] w_obs = {hyper_cs_no, ck_ena_o, busy_o, active_chip_o, csm_expired_o};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input int c, input logic [5:0] v);
      q.push_back('{c, v});
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      tick(3);
      check({name, " leftover events"}, q.size(), 0);
      q.delete();
   endtask

   always @(negedge clk) begin
      if (!rst_ni) begin
         prev      = w_obs;
         seen_rise = 1'b0;
      end else begin
         check("cs onehot", ($countones(~hyper_cs_no) <= 1), 1);
         if (w_obs !== prev) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected change at cycle %0d: got %h expected %h", cyc, w_obs, prev);
            end else begin
               ev = q.pop_front();
               check("event cycle", cyc, ev.cyc);
               check("event value", w_obs, ev.v);
            end
            if (&hyper_cs_no && !(&prev[5:4])) begin
               last_rise = cyc;
               rise_cshi = int'(cfg_t_cshi_i);
               seen_rise = 1'b1;
            end else if (!(&hyper_cs_no) && (&prev[5:4]) && seen_rise) begin
               check("cs high min", ((cyc - last_rise) >= rise_cshi + 2), 1);
            end
         end
         prev = w_obs;
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_ni = 1'b0;
      tick(2);
      check("reset cs_n", hyper_cs_no, 2'b11);
      check("reset ck_ena", ck_ena_o, 0);
      check("reset busy", busy_o, 0);
      check("reset chip", active_chip_o, 0);
      check("reset csm_exp", csm_expired_o, 0);
      rst_ni = 1'b1;
      tick(2);

      // Nominal
      cfg_t_css_i = 2; cfg_t_csh_i = 1; cfg_t_cshi_i = 3; cfg_t_csm_i = 0; cs_i = 2'b10;
      tick(1); k = cyc; cs_ena_i = 1'b1;
      expect_ev(k+1,  6'b01_0_1_1_0);
      expect_ev(k+4,  6'b01_1_1_1_0);
      expect_ev(k+11, 6'b01_0_1_1_0);
      expect_ev(k+13, 6'b11_0_1_1_0);
      expect_ev(k+17, 6'b11_0_0_1_0);
      tick(10); cs_ena_i = 1'b0;
      tick(10); drain("nominal");

      // Multi-hot request, cs_i change mid-ACTIVE ignored
      cfg_t_css_i = 0; cfg_t_csh_i = 0; cfg_t_cshi_i = 0; cs_i = 2'b11;
      tick(1); k = cyc; cs_ena_i = 1'b1;
      expect_ev(k+1, 6'b10_0_1_0_0);
      expect_ev(k+2, 6'b10_1_1_0_0);
      expect_ev(k+7, 6'b10_0_1_0_0);
      expect_ev(k+8, 6'b11_0_1_0_0);
      expect_ev(k+9, 6'b11_0_0_0_0);
      tick(3); cs_i = 2'b10;
      tick(3); cs_ena_i = 1'b0;
      tick(5); drain("multihot");

      // Watchdog expiry, wait in RECOVER, then re-arm
      cfg_t_css_i = 0; cfg_t_csh_i = 1; cfg_t_cshi_i = 1; cfg_t_csm_i = 5; cs_i = 2'b01;
      tick(1); k = cyc; cs_ena_i = 1'b1;
      expect_ev(k+1,  6'b10_0_1_0_0);
      expect_ev(k+2,  6'b10_1_1_0_0);
      expect_ev(k+7,  6'b10_0_1_0_1);
      expect_ev(k+8,  6'b10_0_1_0_0);
      expect_ev(k+9,  6'b11_0_1_0_0);
      expect_ev(k+15, 6'b11_0_0_0_0);
      expect_ev(k+18, 6'b10_0_1_0_0);
      expect_ev(k+19, 6'b10_1_1_0_0);
      expect_ev(k+21, 6'b10_0_1_0_0);
      expect_ev(k+23, 6'b11_0_1_0_0);
      expect_ev(k+25, 6'b11_0_0_0_0);
      tick(14); cs_ena_i = 1'b0;
      tick(1);  cfg_t_csm_i = 0;
      tick(2);  cs_ena_i = 1'b1;
      tick(3);  cs_ena_i = 1'b0;
      tick(6);  drain("watchdog");

      // Abort in SETUP
      cfg_t_css_i = 7; cfg_t_csh_i = 1; cfg_t_cshi_i = 0; cs_i = 2'b10;
      tick(1); k = cyc; cs_ena_i = 1'b1;
      expect_ev(k+1, 6'b01_0_1_1_0);
      expect_ev(k+5, 6'b11_0_1_1_0);
      expect_ev(k+6, 6'b11_0_0_1_0);
      tick(2); cs_ena_i = 1'b0;
      tick(5); drain("abort");

      // Back-to-back with request during RECOVER
      cfg_t_css_i = 0; cfg_t_csh_i = 0; cfg_t_cshi_i = 3; cs_i = 2'b01;
      tick(1); k = cyc; cs_ena_i = 1'b1;
      expect_ev(k+1,  6'b10_0_1_0_0);
      expect_ev(k+2,  6'b10_1_1_0_0);
      expect_ev(k+4,  6'b10_0_1_0_0);
      expect_ev(k+5,  6'b11_0_1_0_0);
      expect_ev(k+10, 6'b11_0_0_0_0);
      expect_ev(k+11, 6'b10_0_1_0_0);
      expect_ev(k+12, 6'b10_1_1_0_0);
      expect_ev(k+14, 6'b10_0_1_0_0);
      expect_ev(k+15, 6'b11_0_1_0_0);
      expect_ev(k+19, 6'b11_0_0_0_0);
      tick(3); cs_ena_i = 1'b0;
      tick(2); cs_ena_i = 1'b1;
      tick(4); cs_ena_i = 1'b0;
      tick(1); cs_ena_i = 1'b1;
      tick(3); cs_ena_i = 1'b0;
      tick(7); drain("back2back");

`ifdef HYPERBUS_CS_STATS_EN
      check("stat trx", stat_trx_cnt_o, 7);
      check("stat csm", stat_csm_cnt_o, 1);
`endif

      // Asynchronous reset while ACTIVE
      cfg_t_css_i = 0; cfg_t_csh_i = 0; cfg_t_cshi_i = 0; cs_i = 2'b10;
      tick(1); k = cyc; cs_ena_i = 1'b1;
      expect_ev(k+1, 6'b01_0_1_1_0);
      expect_ev(k+2, 6'b01_1_1_1_0);
      tick(3);
      check("active before reset", ck_ena_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      check("async rst cs_n", hyper_cs_no, 2'b11);
      check("async rst ck_ena", ck_ena_o, 0);
      check("async rst chip", active_chip_o, 0);
`ifdef HYPERBUS_CS_STATS_EN
      check("async rst stat trx", stat_trx_cnt_o, 0);
`endif
      cs_ena_i = 1'b0;
      tick(2); rst_ni = 1'b1;
      tick(2);
      check("post reset busy", busy_o, 0);
      check("post reset cs_n", hyper_cs_no, 2'b11);
      drain("reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
